// File: rtl/display_pkg.sv
// Shared display types and frame geometry for the framebuffer scanout path.
//   ADDR_W / PIX_W : framebuffer address and RGB pixel widths
//   FRAME_SIZE     : default pixels per frame (800x600)
//   fifo_entry_t   : prefetch FIFO payload (pixel plus first-pixel-of-frame tag)
//   scan_state_e   : scanout FSM states
package display_pkg;

  localparam int unsigned ADDR_W     = 20;
  localparam int unsigned PIX_W      = 24;
  localparam int unsigned FRAME_SIZE = 480000;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [PIX_W-1:0]  pix_t;

  typedef struct packed {
    logic first;
    pix_t pix;
  } fifo_entry_t;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_RUN  = 1'b1
  } scan_state_e;

endpackage

// File: rtl/scanout_fifo.sv
// Scanout prefetch FIFO: synchronous push/pop, head visible combinationally.
// Ports:
//   clk, rst_n        : clock, async active-low reset (empties the FIFO)
//   push, push_entry  : write one entry (caller guarantees not full)
//   pop               : drop head entry (caller guarantees not empty)
//   head, empty, count: current head entry, empty flag, occupancy 0..DEPTH
module scanout_fifo
  import display_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  fifo_entry_t             push_entry,
  input  logic                    pop,
  output fifo_entry_t             head,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  fifo_entry_t      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;

  // Storage array needs no reset; occupancy qualifies every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= push_entry;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign head  = mem[rd_ptr_q];
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/fb_scanout_arb.sv
// Framebuffer RAM arbiter between display scanout reads and draw-engine writes.
// Scanout reads are prefetched into a small FIFO; reads win whenever the FIFO
// (plus the read in flight) drops below half, otherwise draw writes win.
// Ports:
//   clk, rst_n                       : clock, async active-low reset
//   video, video_valid, video_ready  : pixel stream to display sink
//   frame_start                      : presented pixel is pixel 0 of a frame
//   wr_addr, wr_data, wr_valid       : draw write request
//   wr_ready                         : draw write granted this cycle
//   mem_addr, mem_we, mem_wdata      : single-port RAM command
//   mem_rdata                        : RAM read data, one cycle after read
//   underrun                         : sticky, sink stalled on empty FIFO in RUN
module fb_scanout_arb
  import display_pkg::*;
#(
  parameter int unsigned FRAME_SIZE = display_pkg::FRAME_SIZE,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [PIX_W-1:0]  video,
  output logic              video_valid,
  input  logic              video_ready,
  output logic              frame_start,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [PIX_W-1:0]  wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [PIX_W-1:0]  mem_wdata,
  input  logic [PIX_W-1:0]  mem_rdata,
  output logic              underrun
);

  localparam int unsigned     CNT_W     = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(FIFO_DEPTH / 2);
  localparam addr_t           LAST_ADDR = ADDR_W'(FRAME_SIZE - 1);

  scan_state_e      state_q, state_d;
  addr_t            rd_ptr_q;
  logic             inflight_q;
  logic             inflight_first_q;
  logic             underrun_q;
  logic             run;
  logic             rd_issue;
  logic             wr_grant;
  logic             wr_in_frame;
  logic             pop;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic [CNT_W-1:0] credit;
  fifo_entry_t      head;

  // Credit counts entries already buffered plus the one read that may be in flight.
  assign credit      = fifo_count + CNT_W'(inflight_q);
  assign wr_in_frame = (32'(wr_addr) < FRAME_SIZE);

  // Arbitration: urgent refill, then draw writes, then opportunistic refill.
  always_comb begin
    rd_issue = 1'b0;
    wr_grant = 1'b0;
    if (credit < HALF_CNT)      rd_issue = 1'b1;
    else if (wr_valid)          wr_grant = 1'b1;
    else if (credit < FULL_CNT) rd_issue = 1'b1;
  end

  // Out-of-frame writes are accepted but never reach the RAM.
  assign wr_ready  = wr_grant;
  assign mem_we    = wr_grant & wr_in_frame;
  assign mem_addr  = mem_we ? wr_addr : rd_ptr_q;
  assign mem_wdata = mem_we ? wr_data : '0;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_FILL;
    else        state_q <= state_d;
  end

  // Next state: prefill the whole FIFO once, then stream until reset.
  always_comb begin
    state_d = state_q;
    run     = 1'b0;
    case (state_q)
      ST_FILL: if (fifo_count == FULL_CNT) state_d = ST_RUN;
      ST_RUN:  run = 1'b1;
      default: state_d = ST_FILL;
    endcase
  end

  // Read pointer, in-flight tracking and sticky underrun flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q         <= '0;
      inflight_q       <= 1'b0;
      inflight_first_q <= 1'b0;
      underrun_q       <= 1'b0;
    end else begin
      inflight_q       <= rd_issue;
      inflight_first_q <= rd_issue && (rd_ptr_q == '0);
      if (rd_issue) rd_ptr_q <= (rd_ptr_q == LAST_ADDR) ? '0 : rd_ptr_q + ADDR_W'(1);
      if (run && fifo_empty && video_ready) underrun_q <= 1'b1;
    end
  end

  scanout_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (inflight_q),
    .push_entry ({inflight_first_q, mem_rdata}),
    .pop        (pop),
    .head       (head),
    .empty      (fifo_empty),
    .count      (fifo_count)
  );

  // Head is gated to zero whenever it is not a valid presented pixel.
  assign video_valid = run & ~fifo_empty;
  assign pop         = video_valid & video_ready;
  assign video       = video_valid ? head.pix : '0;
  assign frame_start = video_valid & head.first;
  assign underrun    = underrun_q;

endmodule

// File: tb/tb_fb_scanout_arb.sv
// Directed self-checking bench for fb_scanout_arb with a 16-pixel frame and a
// behavioural single-port RAM (one-cycle read latency).
module tb_fb_scanout_arb;

  localparam int unsigned FS = 16;

  logic        clk;
  logic        rst_n;
  logic [23:0] video;
  logic        video_valid;
  logic        video_ready;
  logic        frame_start;
  logic [19:0] wr_addr;
  logic [23:0] wr_data;
  logic        wr_valid;
  logic        wr_ready;
  logic [19:0] mem_addr;
  logic        mem_we;
  logic [23:0] mem_wdata;
  logic [23:0] mem_rdata;
  logic        underrun;

  fb_scanout_arb #(
    .FRAME_SIZE (FS),
    .FIFO_DEPTH (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .video       (video),
    .video_valid (video_valid),
    .video_ready (video_ready),
    .frame_start (frame_start),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .mem_addr    (mem_addr),
    .mem_we      (mem_we),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .underrun    (underrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [23:0] init_pix(input int a);
    return 24'hA50000 | 24'(a);
  endfunction

  // RAM: untouched words read back their initial pattern.
  logic        ram_clr;
  logic [15:0] ram_wr;
  logic [23:0] ram_val [16];
  always @(posedge clk) begin
    if (ram_clr) ram_wr <= '0;
    else if (mem_we) begin
      ram_wr[mem_addr[3:0]]  <= 1'b1;
      ram_val[mem_addr[3:0]] <= mem_wdata;
    end
    mem_rdata <= ram_wr[mem_addr[3:0]] ? ram_val[mem_addr[3:0]]
                                       : init_pix(int'(mem_addr[3:0]));
  end

  int          n_err;
  int          n_checks;
  int          exp_idx;
  int          stale_n;
  int          wr_grants;
  int          fs_count;
  logic [23:0] exp_ram [16];
  logic [23:0] prev5;
  logic [23:0] hold;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Release reset, check the first eight read addresses and the fill latency.
  task automatic fill_check();
    int lat;
    lat = -1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      rst_n = 1'b1; video_ready = 1'b1; wr_valid = 1'b0;
      #1;
      if (c < 8) begin
        check("rd_addr", 32'(mem_addr), 32'(c));
        check("rd_we", 32'(mem_we), 0);
      end
      if (video_valid) begin
        lat = c;
        break;
      end
    end
    check("fill_lat", 32'(lat), 10);
    check("first_pix", 32'(video), 32'(exp_ram[0]));
    check("first_fs", 32'(frame_start), 1);
    fs_count = frame_start ? 1 : 0;
    exp_idx  = 1;
  endtask

  // n cycles with sink ready; every cycle must present the next frame pixel.
  task automatic run_pops(input int n, input bit wr);
    logic [23:0] ev;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      video_ready = 1'b1; wr_valid = wr; wr_addr = 20'd20; wr_data = 24'h0BAD00;
      #1;
      check("vvalid", 32'(video_valid), 1);
      if (wr_ready) begin
        wr_grants++;
        check("drop_we", 32'(mem_we), 0);
      end
      if (video_valid) begin
        ev = (k < stale_n && exp_idx == 5) ? prev5 : exp_ram[exp_idx];
        check("pix", 32'(video), 32'(ev));
        check("fs", 32'(frame_start), 32'(exp_idx == 0));
        if (frame_start) fs_count++;
        exp_idx = (exp_idx + 1) % 16;
      end
    end
    wr_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_err = 0; n_checks = 0; exp_idx = 0; stale_n = 0; wr_grants = 0; fs_count = 0;
    prev5 = '0; hold = '0;
    for (int i = 0; i < 16; i++) exp_ram[i] = init_pix(i);
    rst_n = 1'b0; ram_clr = 1'b1;
    video_ready = 1'b0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    repeat (3) @(negedge clk);
    ram_clr = 1'b0;
    video_ready = 1'b1; wr_valid = 1'b1; wr_addr = 20'd2; wr_data = 24'h123456;
    #1;
    check("rst_video", 32'(video), 0);
    check("rst_vvalid", 32'(video_valid), 0);
    check("rst_fs", 32'(frame_start), 0);
    check("rst_wr_ready", 32'(wr_ready), 0);
    check("rst_mem_we", 32'(mem_we), 0);
    check("rst_mem_addr", 32'(mem_addr), 0);
    check("rst_mem_wdata", 32'(mem_wdata), 0);
    check("rst_underrun", 32'(underrun), 0);

    // Fill, then 40 consecutive pops spanning the 15->0 wrap twice.
    fill_check();
    run_pops(39, 1'b0);
    check("fs_count", 32'(fs_count), 3);

    // Sink stall: head held steady while the FIFO tops up.
    @(negedge clk);
    video_ready = 1'b0; wr_valid = 1'b0;
    #1;
    hold = video;
    check("stall_vv", 32'(video_valid), 1);
    check("stall_pix", 32'(hold), 32'(exp_ram[exp_idx]));
    repeat (4) begin
      @(negedge clk); #1;
      check("stall_hold", 32'(video), 32'(hold));
    end

    // In-frame write on a full FIFO goes straight to the RAM.
    @(negedge clk);
    wr_valid = 1'b1; wr_addr = 20'd5; wr_data = 24'hFF0000;
    #1;
    check("wr_ready", 32'(wr_ready), 1);
    check("wr_mem_we", 32'(mem_we), 1);
    check("wr_mem_addr", 32'(mem_addr), 5);
    check("wr_mem_wdata", 32'(mem_wdata), 32'h00FF0000);
    check("wr_hold", 32'(video), 32'(hold));

    // Out-of-frame write is accepted and dropped.
    @(negedge clk);
    wr_addr = 20'd16; wr_data = 24'h123456;
    #1;
    check("oob_ready", 32'(wr_ready), 1);
    check("oob_we", 32'(mem_we), 0);

    // The 8 prefetched pixels predate the write; later ones see FF0000 at 5.
    prev5 = exp_ram[5];
    exp_ram[5] = 24'hFF0000;
    stale_n = 8;
    run_pops(40, 1'b0);
    stale_n = 0;

    // Continuous writes: four grants drain credit to 3, then reads hold it.
    wr_grants = 0;
    run_pops(30, 1'b1);
    check("wr_grants", 32'(wr_grants), 4);
    check("underrun_0", 32'(underrun), 0);

    // Mid-cycle reset with a read in flight and a write pending.
    @(negedge clk);
    video_ready = 1'b1; wr_valid = 1'b1; wr_addr = 20'd3; wr_data = 24'h00FF00;
    #3;
    rst_n = 1'b0;
    #1;
    check("mrst_video", 32'(video), 0);
    check("mrst_vvalid", 32'(video_valid), 0);
    check("mrst_fs", 32'(frame_start), 0);
    check("mrst_wr_ready", 32'(wr_ready), 0);
    check("mrst_mem_we", 32'(mem_we), 0);
    check("mrst_mem_addr", 32'(mem_addr), 0);
    check("mrst_mem_wdata", 32'(mem_wdata), 0);
    repeat (2) @(negedge clk);
    fill_check();
    run_pops(20, 1'b0);
    check("underrun_end", 32'(underrun), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
